// File: rtl/div_pkg.sv
// Shared widths and FSM state encoding for the 32/16 sequential divider.
package div_pkg;
  localparam int DIVIDEND_W = 32;
  localparam int DIVISOR_W  = 16;
  localparam int CNT_W      = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, keep or restore, emit quotient bit.
module div_step
  import div_pkg::*;
(
  input  logic [DIVISOR_W-1:0] rem_in,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W-1:0] rem_out,
  output logic                 q_bit
);
  logic [DIVISOR_W:0]   partial;
  logic [DIVISOR_W+1:0] diff;

  // The 17-bit partial can exceed 0xFFFF when divisor >= 0x8000, so the
  // subtract runs one bit wider and the top bit is the borrow.
  always_comb begin
    partial = {rem_in, bit_in};
    diff    = {1'b0, partial} - {2'b00, divisor};
    q_bit   = ~diff[DIVISOR_W+1];
    rem_out = q_bit ? diff[DIVISOR_W-1:0] : partial[DIVISOR_W-1:0];
  end
endmodule

// File: rtl/seq_div32_16.sv
// Sequential restoring divider, 32-bit dividend / 16-bit divisor, one
// quotient bit per clock MSB first. Define DIV_SIGNED_EN for two's
// complement operands (magnitude divide plus one sign fix-up cycle).
module seq_div32_16
  import div_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_zero
);
  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] quo_q, quo_d;   // dividend shifts out, quotient shifts in
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic [DIVISOR_W-1:0]  dsr_q, dsr_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic                  dz_q, dz_d;
  logic [DIVISOR_W-1:0]  step_rem;
  logic                  step_bit;
  logic                  accept;
`ifdef DIV_SIGNED_EN
  logic                  fix_q, fix_d;     // last CALC cycle applies signs
  logic                  qneg_q, qneg_d;
  logic                  rneg_q, rneg_d;
`endif

  div_step u_step (
    .rem_in  (rem_q),
    .bit_in  (quo_q[DIVIDEND_W-1]),
    .divisor (dsr_q),
    .rem_out (step_rem),
    .q_bit   (step_bit)
  );

  assign accept = in_valid && in_ready_q;

  // Next-state and datapath update for the IDLE/CALC/DONE sequence.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    dsr_d       = dsr_q;
    out_valid_d = out_valid_q;
    dz_d        = dz_q;
`ifdef DIV_SIGNED_EN
    fix_d       = fix_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d = '0;
          rem_d = '0;
          dz_d  = 1'b0;
`ifdef DIV_SIGNED_EN
          quo_d  = dividend[DIVIDEND_W-1] ? (~dividend + 32'd1) : dividend;
          dsr_d  = divisor[DIVISOR_W-1]   ? (~divisor + 16'd1)  : divisor;
          qneg_d = dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
          rneg_d = dividend[DIVIDEND_W-1];
          fix_d  = 1'b0;
`else
          quo_d = dividend;
          dsr_d = divisor;
`endif
          if (divisor == '0) begin
            state_d     = DONE;
            quo_d       = '1;
            rem_d       = dividend[DIVISOR_W-1:0];
            dz_d        = 1'b1;
            out_valid_d = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
`ifdef DIV_SIGNED_EN
        if (fix_q) begin
          quo_d       = qneg_q ? (~quo_q + 32'd1) : quo_q;
          rem_d       = rneg_q ? (~rem_q + 16'd1) : rem_q;
          fix_d       = 1'b0;
          state_d     = DONE;
          out_valid_d = 1'b1;
        end else begin
          quo_d = {quo_q[DIVIDEND_W-2:0], step_bit};
          rem_d = step_rem;
          cnt_d = cnt_q + CNT_W'(1);
          if (&cnt_q) fix_d = 1'b1;
        end
`else
        quo_d = {quo_q[DIVIDEND_W-2:0], step_bit};
        rem_d = step_rem;
        cnt_d = cnt_q + CNT_W'(1);
        if (&cnt_q) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
`endif
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  // State and registered outputs; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dsr_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      dz_q        <= 1'b0;
`ifdef DIV_SIGNED_EN
      fix_q       <= 1'b0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      dsr_q       <= dsr_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      dz_q        <= dz_d;
`ifdef DIV_SIGNED_EN
      fix_q       <= fix_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign div_zero  = dz_q;
endmodule

// File: tb/tb_seq_div32_16.sv
// Directed bench for seq_div32_16; follows DIV_SIGNED_EN for its vectors.
module tb_seq_div32_16;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [15:0] remainder;
  logic        div_zero;

  int errors = 0;
  int checks = 0;

`ifdef DIV_SIGNED_EN
  localparam int LAT = 33;
`else
  localparam int LAT = 32;
`endif

  seq_div32_16 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation, scramble inputs after accept, measure the edge
  // count to out_valid (0 = visible in the cycle right after accept),
  // optionally stall, then hand the result off.
  task automatic run_op(input string tag, input logic [31:0] dvd, input logic [15:0] dsr,
                        input logic [31:0] eq, input logic [15:0] er, input logic edz,
                        input int elat, input int stall);
    int n;
    chk({tag, ":in_ready_pre"}, 64'(in_ready), 64'd1);
    dividend = dvd;
    divisor  = dsr;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    if (elat > 0) chk({tag, ":in_ready_busy"}, 64'(in_ready), 64'd0);
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ":latency"}, 64'(n), 64'(elat));
    chk({tag, ":quotient"}, 64'(quotient), 64'(eq));
    chk({tag, ":remainder"}, 64'(remainder), 64'(er));
    chk({tag, ":div_zero"}, 64'(div_zero), 64'(edz));
    for (int i = 0; i < stall; i++) begin
      out_ready = 1'b0;
      @(posedge clk); #1;
      chk({tag, ":stall_valid"}, 64'(out_valid), 64'd1);
      chk({tag, ":stall_q"}, 64'(quotient), 64'(eq));
      chk({tag, ":stall_r"}, 64'(remainder), 64'(er));
      chk({tag, ":stall_dz"}, 64'(div_zero), 64'(edz));
      chk({tag, ":stall_in_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ":valid_drop"}, 64'(out_valid), 64'd0);
    chk({tag, ":in_ready_post"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #12;
    chk("rst:in_ready", 64'(in_ready), 64'd1);
    chk("rst:out_valid", 64'(out_valid), 64'd0);
    chk("rst:quotient", 64'(quotient), 64'd0);
    chk("rst:remainder", 64'(remainder), 64'd0);
    chk("rst:div_zero", 64'(div_zero), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("u100_7", 32'd100, 16'd7, 32'd14, 16'd2, 1'b0, LAT, 0);
    run_op("div0", 32'd1234, 16'd0, 32'hFFFF_FFFF, 16'h04D2, 1'b1, 0, 0);
`ifdef DIV_SIGNED_EN
    run_op("s_m100_7", 32'hFFFF_FF9C, 16'd7, 32'hFFFF_FFF2, 16'hFFFE, 1'b0, LAT, 0);
    run_op("s_100_m7", 32'd100, 16'hFFF9, 32'hFFFF_FFF2, 16'd2, 1'b0, LAT, 0);
    run_op("s_m7_m2", 32'hFFFF_FFF9, 16'hFFFE, 32'd3, 16'hFFFF, 1'b0, LAT, 0);
    run_op("s_wrap", 32'h8000_0000, 16'hFFFF, 32'h8000_0000, 16'd0, 1'b0, LAT, 0);
    run_op("s_div0_neg", 32'hFFFF_8765, 16'd0, 32'hFFFF_FFFF, 16'h8765, 1'b1, 0, 0);
`else
    run_op("max_ffff", 32'hFFFF_FFFF, 16'hFFFF, 32'h0001_0001, 16'd0, 1'b0, LAT, 0);
    run_op("big_dsr", 32'h1234_5678, 16'h8001,
           32'h1234_5678 / 32'h0000_8001, 16'(32'h1234_5678 % 32'h0000_8001), 1'b0, LAT, 0);
    run_op("small", 32'd5, 16'd9, 32'd0, 16'd5, 1'b0, LAT, 0);
    run_op("by_one", 32'hDEAD_BEEF, 16'd1, 32'hDEAD_BEEF, 16'd0, 1'b0, LAT, 0);
`endif
    // Backpressure: result must sit unchanged for 5 stalled cycles.
    run_op("stall", 32'd100, 16'd7, 32'd14, 16'd2, 1'b0, LAT, 5);

    // Reset 10 cycles into CALC discards the operation.
    dividend = 32'd100;
    divisor  = 16'd7;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst:out_valid", 64'(out_valid), 64'd0);
    chk("midrst:in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    rst  = 1'b0;
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen |= out_valid;
    end
    out_ready = 1'b0;
    chk("midrst:no_result", 64'(seen), 64'd0);
    run_op("after_rst", 32'd100, 16'd7, 32'd14, 16'd2, 1'b0, LAT, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
